// File: rtl/tbu_deser_pkg.sv
// Shared types and defaults for the traceback-unit deserializer and its output FIFO.
package tbu_deser_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int WORD_MAX_W     = 32;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Entries are sized for the widest legal word; narrower builds zero-extend.
    typedef struct packed {
        logic                  partial;
        logic [WORD_MAX_W-1:0] word;
    } fifo_entry_t;

endpackage

// File: rtl/tbu_deserializer_if.sv
// Serial-in / word-out bus of the deserializer; master drives bits and ready, slave is the DUT.
interface tbu_deserializer_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                            data_serial_i;
    logic                            valid_serial_i;
    logic                            sof_i;
    logic                            msb_first_i;
    logic                            flush_i;
    logic                            word_ready_i;
    logic [DATA_W-1:0]               word_o;
    logic                            word_valid_o;
    logic                            word_partial_o;
    logic                            overflow_o;
    logic [$clog2(FIFO_DEPTH):0]     level_o;

    modport master (
        output data_serial_i, valid_serial_i, sof_i, msb_first_i, flush_i, word_ready_i,
        input  word_o, word_valid_o, word_partial_o, overflow_o, level_o
    );

    modport slave (
        input  data_serial_i, valid_serial_i, sof_i, msb_first_i, flush_i, word_ready_i,
        output word_o, word_valid_o, word_partial_o, overflow_o, level_o
    );

endinterface

// File: rtl/tbu_deser_fifo.sv
// Synchronous FIFO with registered occupancy; a push into a full FIFO succeeds only alongside a pop.
module tbu_deser_fifo
    import tbu_deser_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  fifo_entry_t               entry_i,
    input  logic                      pop_i,
    output fifo_entry_t               entry_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      drop_o,
    output logic [level_w(DEPTH)-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_w(DEPTH);

    fifo_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & ~do_push;
    assign level_o = level_q;
    assign entry_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end

endmodule

// File: rtl/tbu_deserializer.sv
// Packs the traceback bit stream into DATA_W-bit words and queues them for a valid/ready consumer.
// Optional partial-word flush is enabled by defining TBU_DESER_FLUSH_EN.
module tbu_deserializer
    import tbu_deser_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input logic               clk,
    input logic               rst_n,
    tbu_deserializer_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int LVL_W = level_w(FIFO_DEPTH);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] word_nxt, bit_vec;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_eff, pos;
    logic              msb_q, msb_d, order;
    logic              complete, flush_push, push, pop;
    logic              full, empty, drop;
    logic              overflow_q, overflow_d;
    logic [LVL_W-1:0]  level;
    fifo_entry_t       push_entry, head;
    logic              unused_head;

    // A start-of-frame bit restarts the word as index 0, discarding any partial bits.
    always_comb begin
        cnt_eff  = bus.sof_i ? '0 : cnt_q;
        order    = (cnt_eff == '0) ? bus.msb_first_i : msb_q;
        pos      = order ? (CNT_W'(DATA_W - 1) - cnt_eff) : cnt_eff;
        bit_vec  = DATA_W'(bus.data_serial_i) << pos;
        word_nxt = shift_q;
        complete = 1'b0;
        if (bus.valid_serial_i) begin
            word_nxt = (bus.sof_i ? '0 : shift_q) | bit_vec;
            complete = (cnt_eff == CNT_W'(DATA_W - 1));
        end
    end

`ifdef TBU_DESER_FLUSH_EN
    assign flush_push         = bus.flush_i & ~complete & (bus.valid_serial_i | (cnt_q != '0));
    assign bus.word_partial_o = head.partial;
`else
    logic unused_flush;
    assign unused_flush       = bus.flush_i;
    assign flush_push         = 1'b0;
    assign bus.word_partial_o = 1'b0;
`endif

    assign push = complete | flush_push;
    assign pop  = ~empty & bus.word_ready_i;

    always_comb begin
        push_entry                 = '0;
        push_entry.partial         = flush_push;
        push_entry.word[DATA_W-1:0] = word_nxt;
    end

    // Any pushed word, delivered or dropped, restarts the collector at index 0.
    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        msb_d      = msb_q;
        overflow_d = overflow_q | drop;
        if (push) begin
            shift_d = '0;
            cnt_d   = '0;
            msb_d   = order;
        end else if (bus.valid_serial_i) begin
            shift_d = word_nxt;
            cnt_d   = cnt_eff + CNT_W'(1);
            msb_d   = order;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            msb_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            msb_q      <= msb_d;
            overflow_q <= overflow_d;
        end
    end

    tbu_deser_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .entry_o (head),
        .full_o  (full),
        .empty_o (empty),
        .drop_o  (drop),
        .level_o (level)
    );

    assign unused_head      = ^head;
    assign bus.word_o       = head.word[DATA_W-1:0];
    assign bus.word_valid_o = ~empty;
    assign bus.overflow_o   = overflow_q;
    assign bus.level_o      = level;

endmodule

// File: tb/tb_tbu_deserializer.sv
// Self-checking bench for tbu_deserializer: directed literal cases plus randomized traffic against a queue model.
// Flush behaviour is expected only when TBU_DESER_FLUSH_EN is defined.
module tb_tbu_deserializer;
    import tbu_deser_pkg::*;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tbu_deserializer_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    tbu_deserializer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: collected bits in arrival order, FIFO as parallel queues.
    bit                cbits[$];
    bit                corder;
    logic [DATA_W-1:0] mw[$];
    bit                mp[$];
    bit                movf;
    logic [DATA_W-1:0] nw;
    bit                np, haveWord, popNow;

    function automatic logic [DATA_W-1:0] packBits();
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < cbits.size(); i++) begin
            if (corder) w[DATA_W-1-i] = cbits[i];
            else        w[i]          = cbits[i];
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cbits.delete();
            mw.delete();
            mp.delete();
            movf = 1'b0;
        end else begin
            popNow   = (mw.size() != 0) && bus.word_ready_i;
            haveWord = 1'b0;
            np       = 1'b0;
            nw       = '0;
            if (bus.valid_serial_i) begin
                if (bus.sof_i) cbits.delete();
                if (cbits.size() == 0) corder = bus.msb_first_i;
                cbits.push_back(bus.data_serial_i);
                if (cbits.size() == DATA_W) begin
                    nw       = packBits();
                    haveWord = 1'b1;
                    cbits.delete();
                end
            end
`ifdef TBU_DESER_FLUSH_EN
            if (bus.flush_i && !haveWord && cbits.size() != 0) begin
                nw       = packBits();
                np       = 1'b1;
                haveWord = 1'b1;
                cbits.delete();
            end
`endif
            if (popNow) begin
                void'(mw.pop_front());
                void'(mp.pop_front());
            end
            if (haveWord) begin
                if (mw.size() < FIFO_DEPTH) begin
                    mw.push_back(nw);
                    mp.push_back(np);
                end else begin
                    movf = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("cyc_valid", 32'(bus.word_valid_o), 32'(mw.size() != 0));
        checkOutput("cyc_level", 32'(bus.level_o), 32'(mw.size()));
        checkOutput("cyc_overflow", 32'(bus.overflow_o), 32'(movf));
        if (mw.size() != 0) begin
            checkOutput("cyc_word", 32'(bus.word_o), 32'(mw[0]));
            checkOutput("cyc_partial", 32'(bus.word_partial_o), 32'(mp[0]));
        end
    end

    task automatic applyStimulus(input logic d, input logic v, input logic s, input logic m, input logic f);
        bus.data_serial_i  = d;
        bus.valid_serial_i = v;
        bus.sof_i          = s;
        bus.msb_first_i    = m;
        bus.flush_i        = f;
        @(posedge clk);
        #1;
        bus.valid_serial_i = 1'b0;
        bus.sof_i          = 1'b0;
        bus.flush_i        = 1'b0;
    endtask

    // Sends the first n bits of pat starting at pat[7]; toggle flips msb_first_i on later bits.
    task automatic sendSeq(input logic [7:0] pat, input int n, input logic msb,
                           input logic toggle, input logic firstSof, input int maxGap);
        logic m;
        for (int i = 0; i < n; i++) begin
            m = (toggle && (i % 2 == 1)) ? ~msb : msb;
            applyStimulus(pat[7-i], 1'b1, firstSof && (i == 0), m, 1'b0);
            if (maxGap > 0 && i < n - 1) begin
                repeat ($urandom_range(0, maxGap)) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, ~m, 1'b0);
            end
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
    endtask

    logic [7:0] exp5 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        bus.data_serial_i  = 1'b0;
        bus.valid_serial_i = 1'b0;
        bus.sof_i          = 1'b0;
        bus.msb_first_i    = 1'b1;
        bus.flush_i        = 1'b0;
        bus.word_ready_i   = 1'b1;
        #1;
        doReset();

        checkOutput("reset_valid", 32'(bus.word_valid_o), 32'd0);
        checkOutput("reset_word", 32'(bus.word_o), 32'd0);
        checkOutput("reset_level", 32'(bus.level_o), 32'd0);
        checkOutput("reset_overflow", 32'(bus.overflow_o), 32'd0);
        checkOutput("reset_partial", 32'(bus.word_partial_o), 32'd0);

        $display("[TB] MSB-first word");
        sendSeq(8'b1011_0010, 8, 1'b1, 1'b0, 1'b0, 0);
        checkOutput("msb_valid", 32'(bus.word_valid_o), 32'd1);
        checkOutput("msb_word", 32'(bus.word_o), 32'h0000_00B2);
        checkOutput("msb_level", 32'(bus.level_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("msb_level_after_pop", 32'(bus.level_o), 32'd0);

        $display("[TB] LSB-first word with msb_first_i toggling mid-word");
        sendSeq(8'b1011_0010, 8, 1'b0, 1'b1, 1'b0, 0);
        checkOutput("lsb_word", 32'(bus.word_o), 32'h0000_004D);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] start-of-frame realignment");
        sendSeq(8'b1110_0000, 3, 1'b1, 1'b0, 1'b0, 0);
        checkOutput("sof_no_early_word", 32'(bus.word_valid_o), 32'd0);
        sendSeq(8'b0000_1111, 8, 1'b1, 1'b0, 1'b1, 0);
        checkOutput("sof_word", 32'(bus.word_o), 32'h0000_000F);
        checkOutput("sof_level", 32'(bus.level_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("sof_single_word", 32'(bus.word_valid_o), 32'd0);

        $display("[TB] backpressure and overflow");
        bus.word_ready_i = 1'b0;
        for (int w = 0; w < 5; w++) sendSeq(exp5[w], 8, 1'b1, 1'b0, 1'b0, 0);
        checkOutput("bp_level", 32'(bus.level_o), 32'd4);
        checkOutput("bp_overflow", 32'(bus.overflow_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("bp_word_stable", 32'(bus.word_o), 32'(exp5[0]));
        bus.word_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("bp_pop_order", 32'(bus.word_o), 32'(exp5[k]));
            @(posedge clk);
            #1;
        end
        checkOutput("bp_drained", 32'(bus.word_valid_o), 32'd0);
        checkOutput("bp_overflow_sticky", 32'(bus.overflow_o), 32'd1);

        $display("[TB] valid gaps inside a word");
        sendSeq(8'hC5, 8, 1'b1, 1'b0, 1'b0, 5);
        checkOutput("gap_word", 32'(bus.word_o), 32'h0000_00C5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset mid-word");
        sendSeq(8'hF0, 4, 1'b1, 1'b0, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(bus.word_valid_o), 32'd0);
        checkOutput("midrst_level", 32'(bus.level_o), 32'd0);
        checkOutput("midrst_overflow", 32'(bus.overflow_o), 32'd0);
        checkOutput("midrst_word", 32'(bus.word_o), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sendSeq(8'h3C, 8, 1'b1, 1'b0, 1'b0, 0);
        checkOutput("midrst_fresh_word", 32'(bus.word_o), 32'h0000_003C);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] flush of a partial word");
        sendSeq(8'b1010_0000, 3, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef TBU_DESER_FLUSH_EN
        checkOutput("flush_valid", 32'(bus.word_valid_o), 32'd1);
        checkOutput("flush_word", 32'(bus.word_o), 32'h0000_00A0);
        checkOutput("flush_partial", 32'(bus.word_partial_o), 32'd1);
`else
        checkOutput("flush_ignored_valid", 32'(bus.word_valid_o), 32'd0);
        checkOutput("flush_ignored_level", 32'(bus.level_o), 32'd0);
`endif
        doReset();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            bus.word_ready_i = (i % 150 < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 24) == 0);
        end
        bus.word_ready_i = 1'b1;
        repeat (FIFO_DEPTH + 2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("final_drained", 32'(bus.word_valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/tbu_deserializer.md
# tbu_deserializer

Parametrised serial-to-parallel converter between the traceback unit and the system output. It packs the decoded bit stream into DATA_W-bit words, supports MSB-first or LSB-first ordering, realigns on a start-of-frame marker and buffers completed words in a small FIFO. The FIFO drains over a valid/ready handshake, so downstream backpressure no longer loses words silently.

## Interface
- DATA_W, 8, word width in bits, 2..32
- FIFO_DEPTH, 4, output FIFO entries, power of two, 2..16
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- data_serial_i  in  1  decoded bit from traceback
- valid_serial_i  in  1  data_serial_i is valid this cycle
- sof_i  in  1  qualified by valid_serial_i: this bit is bit 0 of a new word
- msb_first_i  in  1  1 = first bit lands in MSB, 0 = first bit lands in LSB; sampled only on the first bit of a word
- flush_i  in  1  emit partial word (only with TBU_DESER_FLUSH_EN)
- word_o  out  DATA_W  head-of-FIFO word
- word_valid_o  out  1  FIFO non-empty
- word_ready_i  in  1  consumer accepts word_o when word_valid_o is high
- word_partial_o  out  1  head word was produced by flush
- overflow_o  out  1  sticky: a completed word was dropped
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Collector: shift register, bit counter cnt (0..DATA_W-1) and a latched order bit.
- Accepted bit (valid_serial_i=1):
  - If cnt==0 or sof_i=1, latch the order bit from msb_first_i.
  - Place the bit at position DATA_W-1-cnt (MSB-first) or at cnt (LSB-first).
  - sof_i=1 discards any partial word and the bit becomes index 0; cnt becomes 1.
- When the accepted bit is index DATA_W-1, the assembled word is pushed and cnt returns to 0.
- Gaps in valid_serial_i hold all state. A partial word is never dropped by an idle gap.
- FIFO handshake:
  - Pop when word_valid_o && word_ready_i.
  - Push when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Push and pop in the same cycle leave the level unchanged.
- Overflow: a word that completes while the FIFO is full with no pop is discarded. overflow_o sets and stays set until reset. The collector still restarts at cnt=0.
- Unfilled bit positions of any word read as 0.

## Timing
- Reset values: word_o=0, word_valid_o=0, word_partial_o=0, overflow_o=0, level_o=0, cnt=0, FIFO empty.
- Reset mid-word discards all state immediately.
- Latency: if the last bit is accepted at edge N, word_valid_o is high after edge N with word_o valid.
- A pop at edge M presents the next entry after edge M.
- word_o and word_partial_o hold stable while word_valid_o=1 and word_ready_i=0.
- Sustained rate is one word per DATA_W accepted bits. With word_ready_i tied high the FIFO never exceeds 1 entry.

## Configuration
- TBU_DESER_FLUSH_EN defined:
  - flush_i with cnt>0 pushes the partial word, zero-padded in the unfilled positions, with word_partial_o=1, then sets cnt=0.
  - The padded positions are the low bits for MSB-first and the high bits for LSB-first.
  - flush_i with cnt==0 does nothing.
  - If flush_i and an accepted bit arrive in the same cycle, the bit is included first. If that bit completes the word, it is pushed as a full word and no extra push occurs.
  - A flush into a full FIFO follows the overflow rule.
- TBU_DESER_FLUSH_EN undefined: flush_i is ignored, and word_partial_o is the constant 0.

## Structure
- Shared package tbu_deser_pkg:
  - DATA_W and FIFO_DEPTH defaults
  - the level-width function
  - the FIFO entry struct {partial, word}
- One sub-module, tbu_deser_fifo: synchronous FIFO with registered occupancy, and push/pop/full/empty using the same-cycle rule above.
- The collector stays in the top module.

## Test plan
- DATA_W=8, msb_first_i=1, bits 1,0,1,1,0,0,1,0 back-to-back, ready high → one word 0xB2 valid the cycle after the 8th bit, level_o returns to 0 on pop.
- Same bits with msb_first_i=0 → word 0x4D. Toggling msb_first_i mid-word has no effect on that word.
- Three bits 1,1,1, then sof_i with bits 0,0,0,0,1,1,1,1 (MSB-first) → single word 0x0F, the partial bits are discarded.
- Ready held low, 5 words pushed with FIFO_DEPTH=4 → level_o=4, overflow_o=1, the 5th word is lost. Ready then rises → the first 4 words pop in order.
- Valid gaps of 0–5 random cycles inside a word → same word as the gapless run. Reset asserted after 4 bits → all outputs 0, and the next 8 bits form a fresh word.
- With TBU_DESER_FLUSH_EN, MSB-first bits 1,0,1 then flush_i → 0xA0 with word_partial_o=1. Without the macro, flush_i → no word.
